scoreboard_hazard_unit: RTL and testbench

- Sequential successor to the decode-stage data-hazard check.
- Keeps a per-architectural-register count of outstanding writes, updated by issue and by N writeback ports.
- Gives the decode stage a hazard/stall decision using the same operand-type and store rules as the current check.
- Adds optional writeback bypass, WAW depth limiting, flush, error flagging and stall statistics.

---
 rtl/scoreboard_hazard_unit_if.sv | 31 +++
 rtl/scoreboard_hazard_unit.sv | 113 +++++++++++
 tb/tb_scoreboard_hazard_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode/writeback bundle between the decode stage (master) and the scoreboard
// hazard unit (slave).
interface scoreboard_hazard_unit_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_WB_PORTS   = 2
);
  logic                                   dec_valid;
  logic [REG_ADDR_WIDTH-1:0]              dec_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0]              dec_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0]              dec_rd_addr;
  logic                                   dec_rd_write;
  logic [1:0]                             dec_op1_type;
  logic [1:0]                             dec_op2_type;
  logic                                   dec_is_store;
  logic [NUM_WB_PORTS-1:0]                wb_valid;
  logic [NUM_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_rd_addr;
  logic                                   is_data_hazard;
  logic                                   issue_fire;

  modport master (
    output dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rd_write,
           dec_op1_type, dec_op2_type, dec_is_store, wb_valid, wb_rd_addr,
    input  is_data_hazard, issue_fire
  );

  modport slave (
    input  dec_valid, dec_rs1_addr, dec_rs2_addr, dec_rd_addr, dec_rd_write,
           dec_op1_type, dec_op2_type, dec_is_store, wb_valid, wb_rd_addr,
    output is_data_hazard, issue_fire
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// Per-register outstanding-write scoreboard driving the decode-stage stall,
// with optional writeback bypass, WAW depth limit, flush and stall statistics.
module scoreboard_hazard_unit #(
  parameter int NUM_REGS        = 32,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int NUM_WB_PORTS    = 2,
  parameter int CNT_WIDTH       = 2,
  parameter bit BYPASS_WB       = 1'b1,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  scoreboard_hazard_unit_if.slave    bus,
  input  logic                       flush,
  output logic                       pending_any,
  output logic                       wb_underflow_err,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  localparam logic [1:0] OP_TYPE_REG = 2'd0;
  localparam int WB_CNT_WIDTH = $clog2(NUM_WB_PORTS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0]      cnt      [NUM_REGS];
  logic [CNT_WIDTH-1:0]      cnt_next [NUM_REGS];
  logic [REG_ADDR_WIDTH-1:0] wb_addr  [NUM_WB_PORTS];
  logic [NUM_WB_PORTS-1:0]   wb_vld;
  logic                      rs1_used, rs2_used, rs1_busy, rs2_busy, waw_full;
  logic                      hazard, fire, underflow;

  assign wb_vld = bus.wb_valid;
  for (genvar p = 0; p < NUM_WB_PORTS; p++) begin : g_wb_addr
    assign wb_addr[p] = bus.wb_rd_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
  end

  // Writebacks addressed to register 0 never count, so r0 can never underflow.
  function automatic logic [WB_CNT_WIDTH-1:0] wb_hits(input logic [REG_ADDR_WIDTH-1:0] addr);
    wb_hits = '0;
    if (addr != '0) begin
      for (int p = 0; p < NUM_WB_PORTS; p++) begin
        if (wb_vld[p] && wb_addr[p] == addr) wb_hits = wb_hits + WB_CNT_WIDTH'(1);
      end
    end
  endfunction

  function automatic logic [CNT_WIDTH-1:0] cnt_at(input logic [REG_ADDR_WIDTH-1:0] addr);
    cnt_at = (int'(addr) < NUM_REGS) ? cnt[addr] : '0;
  endfunction

  function automatic logic src_busy(input logic [REG_ADDR_WIDTH-1:0] addr);
    logic [CNT_WIDTH-1:0] c;
    c = cnt_at(addr);
    if (c == '0)                                    src_busy = 1'b0;
    else if (BYPASS_WB && int'(c) == int'(wb_hits(addr))) src_busy = 1'b0;
    else                                            src_busy = 1'b1;
  endfunction

  always_comb begin
    rs1_used = (bus.dec_op1_type == OP_TYPE_REG);
    rs2_used = (bus.dec_op2_type == OP_TYPE_REG) || bus.dec_is_store;
    rs1_busy = src_busy(bus.dec_rs1_addr);
    rs2_busy = src_busy(bus.dec_rs2_addr);
    // Same-cycle writebacks deliberately do not relieve a full WAW counter.
    waw_full = bus.dec_rd_write && (bus.dec_rd_addr != '0) &&
               (cnt_at(bus.dec_rd_addr) == CNT_MAX);
    hazard   = bus.dec_valid &&
               ((rs1_used && rs1_busy) || (rs2_used && rs2_busy) || waw_full);
    fire     = bus.dec_valid && !hazard && !flush;
    bus.is_data_hazard = hazard;
    bus.issue_fire     = fire;
  end

  // NOTE: every variable gets a default before any branch, so no latch is inferred.
  always_comb begin
    int total;
    total     = 0;
    underflow = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) cnt_next[r] = '0;
    if (!flush) begin
      for (int r = 1; r < NUM_REGS; r++) begin
        total = int'(cnt[r]) - int'(wb_hits(REG_ADDR_WIDTH'(r)));
        if (fire && bus.dec_rd_write && int'(bus.dec_rd_addr) == r) total = total + 1;
        if (total < 0) begin
          underflow   = 1'b1;
          cnt_next[r] = '0;
        end else begin
          cnt_next[r] = CNT_WIDTH'(total);
        end
      end
    end
  end

  always_comb begin
    pending_any = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) pending_any = pending_any | (cnt[r] != '0);
  end

  // NOTE: non-blocking assignments keep every register updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array is control state, not a data RAM, so it must be reset.
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      wb_underflow_err <= 1'b0;
      stall_count      <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= cnt_next[r];
      if (underflow) wb_underflow_err <= 1'b1;
      if (hazard && !flush && stall_count != '1)
        stall_count <= stall_count + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed bench for scoreboard_hazard_unit; a second instance with BYPASS_WB=0
// shares the stimulus to check the non-bypassed writeback latency.
module tb_scoreboard_hazard_unit;

  localparam logic [1:0] REG = 2'd0;
  localparam logic [1:0] IMM = 2'd1;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic pending_any, wb_underflow_err;
  logic [31:0] stall_count;
  logic nb_pending_any, nb_wb_underflow_err;
  logic [31:0] nb_stall_count;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scoreboard_hazard_unit_if #(.REG_ADDR_WIDTH(5), .NUM_WB_PORTS(2)) bus ();
  scoreboard_hazard_unit_if #(.REG_ADDR_WIDTH(5), .NUM_WB_PORTS(2)) bus_nb ();

  assign bus_nb.dec_valid    = bus.dec_valid;
  assign bus_nb.dec_rs1_addr = bus.dec_rs1_addr;
  assign bus_nb.dec_rs2_addr = bus.dec_rs2_addr;
  assign bus_nb.dec_rd_addr  = bus.dec_rd_addr;
  assign bus_nb.dec_rd_write = bus.dec_rd_write;
  assign bus_nb.dec_op1_type = bus.dec_op1_type;
  assign bus_nb.dec_op2_type = bus.dec_op2_type;
  assign bus_nb.dec_is_store = bus.dec_is_store;
  assign bus_nb.wb_valid     = bus.wb_valid;
  assign bus_nb.wb_rd_addr   = bus.wb_rd_addr;

  scoreboard_hazard_unit #(.BYPASS_WB(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush),
    .pending_any(pending_any), .wb_underflow_err(wb_underflow_err), .stall_count(stall_count)
  );

  scoreboard_hazard_unit #(.BYPASS_WB(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .bus(bus_nb), .flush(flush),
    .pending_any(nb_pending_any), .wb_underflow_err(nb_wb_underflow_err),
    .stall_count(nb_stall_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rd_w, input logic [1:0] op1,
                         input logic [1:0] op2, input logic store);
    bus.dec_valid    = v;
    bus.dec_rs1_addr = rs1;
    bus.dec_rs2_addr = rs2;
    bus.dec_rd_addr  = rd;
    bus.dec_rd_write = rd_w;
    bus.dec_op1_type = op1;
    bus.dec_op2_type = op2;
    bus.dec_is_store = store;
  endtask

  task automatic set_wb(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1);
    bus.wb_valid   = v;
    bus.wb_rd_addr = {a1, a0};
  endtask

  task automatic idle();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IMM, IMM, 1'b0);
    set_wb(2'b00, 5'd0, 5'd0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    set_dec(1'b1, 5'd5, 5'd6, 5'd5, 1'b1, REG, REG, 1'b0);
    set_wb(2'b11, 5'd5, 5'd6);
    tick();
    tick();
    rst = 1'b0;
    set_dec(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, REG, REG, 1'b0);
    set_wb(2'b00, 5'd0, 5'd0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard: got %b want 0", bus.is_data_hazard); end
    checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL reset_issue_fire: got %b want 1", bus.issue_fire); end
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL reset_stall_count: got %0d want 0", stall_count); end
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL reset_pending_any: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", wb_underflow_err); end
    idle();
    tick();
  endtask

  task automatic test_raw();
    set_dec(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, IMM, IMM, 1'b0);
    #1;
    checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL raw_issue: got %b want 1", bus.issue_fire); end
    tick();
    set_dec(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, REG, IMM, 1'b0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL raw_stall_n1: got %b want 1", bus.is_data_hazard); end
    checks++; if (bus_nb.is_data_hazard !== 1'b1) begin failures++; $display("FAIL raw_nb_stall_n1: got %b want 1", bus_nb.is_data_hazard); end
    tick();
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL raw_stall_n2: got %b want 1", bus.is_data_hazard); end
    tick();
    set_wb(2'b10, 5'd0, 5'd5);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL raw_bypass_clear: got %b want 0", bus.is_data_hazard); end
    checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL raw_bypass_fire: got %b want 1", bus.issue_fire); end
    checks++; if (bus_nb.is_data_hazard !== 1'b1) begin failures++; $display("FAIL raw_nb_still_busy: got %b want 1", bus_nb.is_data_hazard); end
    tick();
    set_wb(2'b00, 5'd0, 5'd0);
    #1;
    checks++; if (bus_nb.is_data_hazard !== 1'b0) begin failures++; $display("FAIL raw_nb_clear: got %b want 0", bus_nb.is_data_hazard); end
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL raw_after_wb: got %b want 0", bus.is_data_hazard); end
    checks++; if (stall_count !== 32'd2) begin failures++; $display("FAIL raw_stall_count: got %0d want 2", stall_count); end
    checks++; if (nb_stall_count !== 32'd3) begin failures++; $display("FAIL raw_nb_stall_count: got %0d want 3", nb_stall_count); end
    idle();
    tick();
  endtask

  task automatic test_operand_types();
    set_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, IMM, IMM, 1'b0);
    tick();
    idle();
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL r0_issue_ignored: got %b want 0", pending_any); end
    set_dec(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, IMM, IMM, 1'b0);
    tick();
    set_dec(1'b1, 5'd0, 5'd7, 5'd0, 1'b0, IMM, IMM, 1'b0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL op2_imm_no_hazard: got %b want 0", bus.is_data_hazard); end
    bus.dec_is_store = 1'b1;
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL store_rs2_hazard: got %b want 1", bus.is_data_hazard); end
    set_dec(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, REG, REG, 1'b1);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL rs_zero_no_hazard: got %b want 0", bus.is_data_hazard); end
    checks++; if (pending_any !== 1'b1) begin failures++; $display("FAIL r7_pending: got %b want 1", pending_any); end
    tick();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IMM, IMM, 1'b0);
    set_wb(2'b11, 5'd7, 5'd0);
    tick();
    idle();
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL r7_drained: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL r0_wb_no_err: got %b want 0", wb_underflow_err); end
  endtask

  task automatic test_waw();
    set_dec(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, IMM, IMM, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL waw_issue_%0d: got %b want 1", i, bus.issue_fire); end
      tick();
    end
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL waw_full_hazard: got %b want 1", bus.is_data_hazard); end
    checks++; if (bus.issue_fire !== 1'b0) begin failures++; $display("FAIL waw_full_no_fire: got %b want 0", bus.issue_fire); end
    tick();
    set_wb(2'b01, 5'd9, 5'd0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL waw_wb_no_relief: got %b want 1", bus.is_data_hazard); end
    tick();
    set_wb(2'b00, 5'd0, 5'd0);
    #1;
    checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL waw_fourth_issues: got %b want 1", bus.issue_fire); end
    tick();
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL waw_refull: got %b want 1", bus.is_data_hazard); end
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IMM, IMM, 1'b0);
    set_wb(2'b11, 5'd9, 5'd9);
    tick();
    set_wb(2'b01, 5'd9, 5'd0);
    tick();
    idle();
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL waw_drained: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL waw_no_err: got %b want 0", wb_underflow_err); end
  endtask

  task automatic test_simultaneous();
    set_dec(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, IMM, IMM, 1'b0);
    tick();
    set_wb(2'b01, 5'd3, 5'd0);
    #1;
    checks++; if (bus.issue_fire !== 1'b1) begin failures++; $display("FAIL net_issue_fire: got %b want 1", bus.issue_fire); end
    tick();
    set_wb(2'b00, 5'd0, 5'd0);
    set_dec(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, REG, IMM, 1'b0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL net_r3_busy: got %b want 1", bus.is_data_hazard); end
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IMM, IMM, 1'b0);
    set_wb(2'b10, 5'd0, 5'd3);
    tick();
    set_wb(2'b00, 5'd0, 5'd0);
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL net_r3_was_one: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL net_no_err: got %b want 0", wb_underflow_err); end
    set_dec(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, IMM, IMM, 1'b0);
    tick();
    set_dec(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IMM, IMM, 1'b0);
    set_wb(2'b11, 5'd4, 5'd4);
    tick();
    set_wb(2'b00, 5'd0, 5'd0);
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL underflow_clamp: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_err: got %b want 1", wb_underflow_err); end
    tick();
    tick();
    checks++; if (wb_underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_sticky: got %b want 1", wb_underflow_err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL err_cleared_by_rst: got %b want 0", wb_underflow_err); end
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL stall_cleared_by_rst: got %0d want 0", stall_count); end
  endtask

  task automatic test_flush();
    set_dec(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, IMM, IMM, 1'b0);
    tick();
    bus.dec_rd_addr = 5'd3;
    tick();
    bus.dec_rd_addr = 5'd8;
    tick();
    idle();
    #1;
    checks++; if (pending_any !== 1'b1) begin failures++; $display("FAIL flush_pre_pending: got %b want 1", pending_any); end
    flush = 1'b1;
    set_dec(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, IMM, IMM, 1'b0);
    set_wb(2'b01, 5'd3, 5'd0);
    #1;
    checks++; if (bus.issue_fire !== 1'b0) begin failures++; $display("FAIL flush_no_fire: got %b want 0", bus.issue_fire); end
    checks++; if (bus.is_data_hazard !== 1'b0) begin failures++; $display("FAIL flush_no_hazard: got %b want 0", bus.is_data_hazard); end
    tick();
    idle();
    #1;
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL flush_cleared: got %b want 0", pending_any); end
    checks++; if (wb_underflow_err !== 1'b0) begin failures++; $display("FAIL flush_no_err: got %b want 0", wb_underflow_err); end
    set_dec(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, IMM, IMM, 1'b0);
    tick();
    flush = 1'b1;
    set_dec(1'b1, 5'd2, 5'd0, 5'd0, 1'b0, REG, IMM, 1'b0);
    #1;
    checks++; if (bus.is_data_hazard !== 1'b1) begin failures++; $display("FAIL flush_hazard_visible: got %b want 1", bus.is_data_hazard); end
    tick();
    idle();
    #1;
    checks++; if (stall_count !== 32'd0) begin failures++; $display("FAIL flush_stall_not_counted: got %0d want 0", stall_count); end
    checks++; if (pending_any !== 1'b0) begin failures++; $display("FAIL flush2_cleared: got %b want 0", pending_any); end
    set_wb(2'b01, 5'd10, 5'd0);
    tick();
    idle();
    #1;
    checks++; if (wb_underflow_err !== 1'b1) begin failures++; $display("FAIL post_flush_underflow: got %b want 1", wb_underflow_err); end
  endtask

  initial begin
    idle();
    test_reset();
    test_raw();
    test_operand_types();
    test_waw();
    test_simultaneous();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
